viterbi_frame_sched: RTL and testbench

Frame-level controller that sequences the Viterbi decoder core (vitebri). It accepts coded 2-bit symbol pairs from an upstream valid/ready stream and buffers one full frame. It then feeds the frame to the decoder as one contiguous burst, waits for the decoder's valid_output, and returns the decoded word on a downstream valid/ready port. It resets the decoder between frames and recovers from a hung decoder through a timeout.

---
 rtl/viterbi_frame_sched.sv | 247 ++++++++++++++++++++++++
 tb/tb_viterbi_frame_sched.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_frame_sched.sv
`default_nettype none
// ============================================================================
// Module   : viterbi_frame_sched
// Desc     : Frame-level sequencer for a Viterbi decoder core. Buffers one
//            frame of coded symbol pairs from an upstream valid/ready stream.
//            Replays the frame to the decoder as one gap-free burst, then
//            waits for the decoder result. The decoded word is returned on a
//            downstream valid/ready port. The decoder is held in reset
//            between frames, and a hung decoder is abandoned after a bounded
//            wait.
// Ports    : clk, reset           - clock, synchronous active-high reset
//            s_valid/s_ready/s_data
//                                 - upstream coded symbol stream (2 bits)
//            dec_reset/dec_valid_input/dec_data_in
//                                 - decoder control and data
//            dec_valid_output/dec_data_out
//                                 - decoder result
//            m_valid/m_ready/m_data
//                                 - downstream decoded frame
//            busy                 - high whenever not accepting symbols
//            timeout_err          - one-cycle pulse when a decode is abandoned
//            frame_cnt            - delivered frame count, wraps at 2^16
// Revision : 1.0 - initial release
// ============================================================================
module viterbi_frame_sched #(
    parameter int FRAME_SYMS = 64,
    parameter int OUT_BITS   = 62,
    parameter int TIMEOUT    = 1023,
    parameter int RST_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [1:0]          s_data,
    output logic                dec_reset,
    output logic                dec_valid_input,
    output logic [1:0]          dec_data_in,
    input  logic                dec_valid_output,
    input  logic [OUT_BITS-1:0] dec_data_out,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [OUT_BITS-1:0] m_data,
    output logic                busy,
    output logic                timeout_err,
    output logic [15:0]         frame_cnt
);

    localparam int C_PTR_W  = $clog2(FRAME_SYMS);
    localparam int C_WCNT_W = $clog2(TIMEOUT + 1);
    localparam int C_RCNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    localparam logic [C_PTR_W-1:0]  C_LAST_PTR  = C_PTR_W'(FRAME_SYMS - 1);
    localparam logic [C_WCNT_W-1:0] C_WAIT_MAX  = C_WCNT_W'(TIMEOUT);
    localparam logic [C_RCNT_W-1:0] C_RST_LAST  = C_RCNT_W'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        S_DRST = 3'd0,
        S_FILL = 3'd1,
        S_FEED = 3'd2,
        S_WAIT = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t                r_state_q,     w_state_d;
    logic [C_RCNT_W-1:0]   r_rst_cnt_q,   w_rst_cnt_d;
    logic [C_PTR_W-1:0]    r_wptr_q,      w_wptr_d;
    logic [C_PTR_W-1:0]    r_rptr_q,      w_rptr_d;
    logic [C_WCNT_W-1:0]   r_wait_cnt_q,  w_wait_cnt_d;
    logic                  r_s_ready_q,   w_s_ready_d;
    logic                  r_dec_reset_q, w_dec_reset_d;
    logic                  r_dec_valid_q, w_dec_valid_d;
    logic [1:0]            r_dec_data_q,  w_dec_data_d;
    logic                  r_m_valid_q,   w_m_valid_d;
    logic [OUT_BITS-1:0]   r_m_data_q,    w_m_data_d;
    logic                  r_busy_q,      w_busy_d;
    logic                  r_timeout_q,   w_timeout_d;
    logic [15:0]           r_frame_cnt_q, w_frame_cnt_d;

    logic [1:0]            r_buf_q [FRAME_SYMS];
    logic                  w_wr_en;
    logic                  w_xfer;
    logic [C_WCNT_W-1:0]   w_wait_inc;

    // s_ready is only ever high in FILL, so this alone qualifies a write.
    assign w_xfer = s_valid & r_s_ready_q;

    always_comb begin
        w_state_d     = r_state_q;
        w_rst_cnt_d   = r_rst_cnt_q;
        w_wptr_d      = r_wptr_q;
        w_rptr_d      = r_rptr_q;
        w_wait_cnt_d  = r_wait_cnt_q;
        w_s_ready_d   = r_s_ready_q;
        w_dec_reset_d = r_dec_reset_q;
        w_dec_valid_d = r_dec_valid_q;
        w_dec_data_d  = r_dec_data_q;
        w_m_valid_d   = r_m_valid_q;
        w_m_data_d    = r_m_data_q;
        w_busy_d      = r_busy_q;
        w_timeout_d   = 1'b0;
        w_frame_cnt_d = r_frame_cnt_q;
        w_wr_en       = 1'b0;
        // Saturating so a very long wait can never alias back to zero.
        w_wait_inc    = (r_wait_cnt_q == C_WAIT_MAX) ? r_wait_cnt_q
                                                     : r_wait_cnt_q + C_WCNT_W'(1);

        case (r_state_q)
            S_DRST: begin
                if (r_rst_cnt_q == C_RST_LAST) begin
                    w_state_d     = S_FILL;
                    w_dec_reset_d = 1'b0;
                    w_s_ready_d   = 1'b1;
                    w_busy_d      = 1'b0;
                    w_wptr_d      = '0;
                end else begin
                    w_rst_cnt_d = r_rst_cnt_q + C_RCNT_W'(1);
                end
            end

            S_FILL: begin
                if (w_xfer) begin
                    w_wr_en  = 1'b1;
                    w_wptr_d = r_wptr_q + C_PTR_W'(1);
                    if (r_wptr_q == C_LAST_PTR) begin
                        // Start the burst straight away: entry 0 has been
                        // stored long before the final symbol arrives.
                        w_state_d     = S_FEED;
                        w_s_ready_d   = 1'b0;
                        w_busy_d      = 1'b1;
                        w_dec_valid_d = 1'b1;
                        w_dec_data_d  = r_buf_q[0];
                        w_rptr_d      = C_PTR_W'(1);
                    end
                end
            end

            S_FEED: begin
                // rptr is the next entry to present; it wraps to zero once
                // the final entry is on the bus (frame size is a power of 2).
                if (r_rptr_q == '0) begin
                    w_state_d     = S_WAIT;
                    w_dec_valid_d = 1'b0;
                    w_dec_data_d  = 2'b00;
                    w_wait_cnt_d  = '0;
                end else begin
                    w_dec_data_d = r_buf_q[r_rptr_q];
                    w_rptr_d     = r_rptr_q + C_PTR_W'(1);
                end
            end

            S_WAIT: begin
                // A result on the final allowed cycle still wins over abort.
                if (dec_valid_output) begin
                    w_state_d   = S_OUT;
                    w_m_valid_d = 1'b1;
                    w_m_data_d  = dec_data_out;
                end else if (w_wait_inc == C_WAIT_MAX) begin
                    w_state_d     = S_DRST;
                    w_timeout_d   = 1'b1;
                    w_dec_reset_d = 1'b1;
                    w_rst_cnt_d   = '0;
                end else begin
                    w_wait_cnt_d = w_wait_inc;
                end
            end

            S_OUT: begin
                if (m_ready) begin
                    w_state_d     = S_DRST;
                    w_m_valid_d   = 1'b0;
                    w_frame_cnt_d = r_frame_cnt_q + 16'd1;
                    w_dec_reset_d = 1'b1;
                    w_rst_cnt_d   = '0;
                end
            end

            default: begin
                w_state_d     = S_DRST;
                w_rst_cnt_d   = '0;
                w_dec_reset_d = 1'b1;
                w_s_ready_d   = 1'b0;
                w_busy_d      = 1'b1;
                w_dec_valid_d = 1'b0;
                w_dec_data_d  = 2'b00;
                w_m_valid_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q     <= S_DRST;
            r_rst_cnt_q   <= '0;
            r_wptr_q      <= '0;
            r_rptr_q      <= '0;
            r_wait_cnt_q  <= '0;
            r_s_ready_q   <= 1'b0;
            r_dec_reset_q <= 1'b1;
            r_dec_valid_q <= 1'b0;
            r_dec_data_q  <= 2'b00;
            r_m_valid_q   <= 1'b0;
            r_m_data_q    <= '0;
            r_busy_q      <= 1'b1;
            r_timeout_q   <= 1'b0;
            r_frame_cnt_q <= 16'd0;
        end else begin
            r_state_q     <= w_state_d;
            r_rst_cnt_q   <= w_rst_cnt_d;
            r_wptr_q      <= w_wptr_d;
            r_rptr_q      <= w_rptr_d;
            r_wait_cnt_q  <= w_wait_cnt_d;
            r_s_ready_q   <= w_s_ready_d;
            r_dec_reset_q <= w_dec_reset_d;
            r_dec_valid_q <= w_dec_valid_d;
            r_dec_data_q  <= w_dec_data_d;
            r_m_valid_q   <= w_m_valid_d;
            r_m_data_q    <= w_m_data_d;
            r_busy_q      <= w_busy_d;
            r_timeout_q   <= w_timeout_d;
            r_frame_cnt_q <= w_frame_cnt_d;
        end
    end

    // Frame storage carries no reset; stale contents are always overwritten
    // by a complete fill before they are replayed.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_buf_q[r_wptr_q] <= s_data;
        end
    end

    assign s_ready         = r_s_ready_q;
    assign dec_reset       = r_dec_reset_q;
    assign dec_valid_input = r_dec_valid_q;
    assign dec_data_in     = r_dec_data_q;
    assign m_valid         = r_m_valid_q;
    assign m_data          = r_m_data_q;
    assign busy            = r_busy_q;
    assign timeout_err     = r_timeout_q;
    assign frame_cnt       = r_frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_viterbi_frame_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_viterbi_frame_sched
// Desc     : Self-checking bench for viterbi_frame_sched. A behavioural
//            decoder stand-in records the burst it is fed. It answers after a
//            programmable latency with a word derived from the received
//            symbols: bit i is the xor of the two bits of symbol i+1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_viterbi_frame_sched;

    localparam int FS = 64;
    localparam int OB = 62;
    localparam int TO = 20;
    localparam int RC = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          s_valid;
    logic          s_ready;
    logic [1:0]    s_data;
    logic          dec_reset;
    logic          dec_valid_input;
    logic [1:0]    dec_data_in;
    logic          dec_valid_output;
    logic [OB-1:0] dec_data_out;
    logic          m_valid;
    logic          m_ready;
    logic [OB-1:0] m_data;
    logic          busy;
    logic          timeout_err;
    logic [15:0]   frame_cnt;

    int checks = 0;
    int errors = 0;

    logic [1:0] tx_syms [FS];
    logic [1:0] rx_syms [FS];
    int rx_cnt = 0, gap_cnt = 0, lat = 0, wait_ctr = 0;
    int rst_run = 0, last_rst_run = 0, mv_cycles = 0, to_pulses = 0;
    int exp_frames = 0;
    bit responded = 1'b0, spur_en = 1'b0, spur_done = 1'b0, sent_ok = 1'b0;

    always #5 clk = ~clk;

    viterbi_frame_sched #(
        .FRAME_SYMS (FS),
        .OUT_BITS   (OB),
        .TIMEOUT    (TO),
        .RST_CYCLES (RC)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .s_data           (s_data),
        .dec_reset        (dec_reset),
        .dec_valid_input  (dec_valid_input),
        .dec_data_in      (dec_data_in),
        .dec_valid_output (dec_valid_output),
        .dec_data_out     (dec_data_out),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .m_data           (m_data),
        .busy             (busy),
        .timeout_err      (timeout_err),
        .frame_cnt        (frame_cnt)
    );

    function automatic logic [OB-1:0] model_decode();
        logic [OB-1:0] w;
        for (int i = 0; i < OB; i++) w[i] = rx_syms[i+1][1] ^ rx_syms[i+1][0];
        return w;
    endfunction

    function automatic logic [OB-1:0] ref_decode();
        logic [OB-1:0] w;
        for (int i = 0; i < OB; i++) w[i] = tx_syms[i+1][1] ^ tx_syms[i+1][0];
        return w;
    endfunction

    // Decoder stand-in plus passive monitors, evaluated just after each edge.
    always @(posedge clk) begin
        #1;
        dec_valid_output = 1'b0;
        if (dec_reset === 1'b1) begin
            rx_cnt    = 0;
            wait_ctr  = 0;
            responded = 1'b0;
            spur_done = 1'b0;
        end else if (dec_valid_input === 1'b1) begin
            if (rx_cnt < FS) rx_syms[rx_cnt] = dec_data_in;
            rx_cnt++;
            if (spur_en && !spur_done && rx_cnt == 10) begin
                dec_valid_output = 1'b1;
                dec_data_out     = '1;
                spur_done        = 1'b1;
            end
        end else if (rx_cnt > 0 && rx_cnt < FS) begin
            gap_cnt++;
        end else if (rx_cnt == FS && !responded) begin
            if (wait_ctr == lat) begin
                dec_valid_output = 1'b1;
                dec_data_out     = model_decode();
                responded        = 1'b1;
            end else begin
                wait_ctr++;
            end
        end
        if (dec_reset === 1'b1) rst_run++;
        else if (rst_run > 0) begin
            last_rst_run = rst_run;
            rst_run      = 0;
        end
        if (m_valid === 1'b1) mv_cycles++;
        if (timeout_err === 1'b1) to_pulses++;
    end

    // ---------------- stimulus helpers (no checking inside) ----------------
    task automatic rand_frame();
        for (int i = 0; i < FS; i++) tx_syms[i] = 2'($urandom_range(0, 3));
    endtask

    task automatic send_frame(input bit gaps);
        int idx = 0;
        int cyc = 0;
        while (idx < FS && cyc < 3000) begin
            s_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
            s_data  = tx_syms[idx];
            if (s_valid && s_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        s_valid = 1'b0;
        s_data  = 2'b00;
        sent_ok = (idx == FS);
    endtask

    task automatic wait_mvalid(output bit ok);
        int n = 0;
        while (m_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = (m_valid === 1'b1);
    endtask

    // ------------------------------- tests -------------------------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready: got %b want 0", s_ready); end
        checks++; if (dec_reset !== 1'b1) begin errors++; $display("FAIL rst_dec_reset: got %b want 1", dec_reset); end
        checks++; if (dec_valid_input !== 1'b0 || dec_data_in !== 2'b00) begin errors++; $display("FAIL rst_dec_in: got %b/%b want 0/00", dec_valid_input, dec_data_in); end
        checks++; if (m_valid !== 1'b0 || m_data !== '0) begin errors++; $display("FAIL rst_m: got %b/%h want 0/0", m_valid, m_data); end
        checks++; if (busy !== 1'b1 || timeout_err !== 1'b0) begin errors++; $display("FAIL rst_busy_to: got %b/%b want 1/0", busy, timeout_err); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL rst_frame_cnt: got %0d want 0", frame_cnt); end
        reset = 1'b0;
        exp_frames = 0;
        @(negedge clk);
        checks++; if (s_ready !== 1'b0 || dec_reset !== 1'b1) begin errors++; $display("FAIL drst_cycle1: s_ready=%b dec_reset=%b want 0/1", s_ready, dec_reset); end
        @(negedge clk);
        checks++; if (s_ready !== 1'b1 || dec_reset !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL fill_entry: s_ready=%b dec_reset=%b busy=%b want 1/0/0", s_ready, dec_reset, busy); end
    endtask

    task automatic test_nominal();
        logic [1:0] pre [8];
        bit ok;
        int mism = 0;
        pre = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b01, 2'b10, 2'b01, 2'b00};
        rand_frame();
        for (int i = 0; i < 8; i++) tx_syms[i] = pre[i];
        gap_cnt = 0; lat = int'($urandom_range(0, 8)); m_ready = 1'b1;
        send_frame(1'b0);
        checks++; if (!sent_ok || s_ready !== 1'b0) begin errors++; $display("FAIL nom_accept: sent_ok=%b s_ready=%b want 1/0", sent_ok, s_ready); end
        checks++; if (dec_valid_input !== 1'b1 || dec_data_in !== tx_syms[0]) begin errors++; $display("FAIL nom_feed_start: valid=%b data=%b want 1/%b", dec_valid_input, dec_data_in, tx_syms[0]); end
        wait_mvalid(ok);
        for (int i = 0; i < FS; i++) if (rx_syms[i] !== tx_syms[i]) mism++;
        checks++; if (rx_cnt != FS || gap_cnt != 0 || mism != 0) begin errors++; $display("FAIL nom_burst: rx=%0d gaps=%0d misorder=%0d want %0d/0/0", rx_cnt, gap_cnt, mism, FS); end
        checks++; if (!ok || m_data !== ref_decode()) begin errors++; $display("FAIL nom_m_data: valid=%b got %h want %h", m_valid, m_data, ref_decode()); end
        exp_frames++;
        @(negedge clk);
        checks++; if (m_valid !== 1'b0 || frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL nom_handshake: m_valid=%b frame_cnt=%0d want 0/%0d", m_valid, frame_cnt, exp_frames); end
    endtask

    task automatic test_gaps();
        bit ok;
        int mism = 0;
        rand_frame();
        gap_cnt = 0; lat = int'($urandom_range(0, 8)); m_ready = 1'b1; spur_en = 1'b1;
        send_frame(1'b1);
        checks++; if (!sent_ok || s_ready !== 1'b0) begin errors++; $display("FAIL gap_accept: sent_ok=%b s_ready=%b want 1/0", sent_ok, s_ready); end
        wait_mvalid(ok);
        spur_en = 1'b0;
        for (int i = 0; i < FS; i++) if (rx_syms[i] !== tx_syms[i]) mism++;
        checks++; if (rx_cnt != FS || gap_cnt != 0 || mism != 0) begin errors++; $display("FAIL gap_burst: rx=%0d gaps=%0d misorder=%0d want %0d/0/0", rx_cnt, gap_cnt, mism, FS); end
        checks++; if (!ok || m_data !== ref_decode()) begin errors++; $display("FAIL gap_m_data: valid=%b got %h want %h", m_valid, m_data, ref_decode()); end
        exp_frames++;
        @(negedge clk);
        checks++; if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL gap_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [OB-1:0] expd;
        rand_frame();
        expd = ref_decode();
        gap_cnt = 0; lat = int'($urandom_range(0, 8)); m_ready = 1'b0;
        send_frame(1'b0);
        wait_mvalid(ok);
        checks++; if (!ok || m_data !== expd) begin errors++; $display("FAIL bp_m_data: valid=%b got %h want %h", m_valid, m_data, expd); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b1 || m_data !== expd || s_ready !== 1'b0 || frame_cnt !== 16'(exp_frames)) begin
                errors++;
                $display("FAIL bp_hold cyc %0d: m_valid=%b m_data=%h s_ready=%b frame_cnt=%0d want 1/%h/0/%0d", c, m_valid, m_data, s_ready, frame_cnt, expd, exp_frames);
            end
        end
        m_ready = 1'b1;
        exp_frames++;
        @(negedge clk);
        checks++; if (m_valid !== 1'b0 || frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL bp_release: m_valid=%b frame_cnt=%0d want 0/%0d", m_valid, frame_cnt, exp_frames); end
    endtask

    // Decoder answers one cycle too late: the frame must be abandoned.
    task automatic test_timeout();
        int n = 0;
        int start_to;
        rand_frame();
        gap_cnt = 0; lat = TO; m_ready = 1'b1; mv_cycles = 0; start_to = to_pulses;
        send_frame(1'b0);
        while (dec_valid_input === 1'b1 && n < 200) begin @(negedge clk); n++; end
        checks++; if (busy !== 1'b1 || s_ready !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL to_wait_entry: busy=%b s_ready=%b timeout_err=%b want 1/0/0", busy, s_ready, timeout_err); end
        n = 1;
        while (timeout_err !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        checks++; if (n != TO + 1) begin errors++; $display("FAIL to_latency: timeout_err seen in cycle %0d after burst, want %0d", n, TO + 1); end
        checks++; if (dec_reset !== 1'b1 || m_valid !== 1'b0) begin errors++; $display("FAIL to_first: dec_reset=%b m_valid=%b want 1/0", dec_reset, m_valid); end
        @(negedge clk);
        checks++; if (timeout_err !== 1'b0 || dec_reset !== 1'b1 || s_ready !== 1'b0) begin errors++; $display("FAIL to_second: timeout_err=%b dec_reset=%b s_ready=%b want 0/1/0", timeout_err, dec_reset, s_ready); end
        @(negedge clk);
        checks++; if (dec_reset !== 1'b0 || s_ready !== 1'b1) begin errors++; $display("FAIL to_refill: dec_reset=%b s_ready=%b want 0/1", dec_reset, s_ready); end
        checks++; if (mv_cycles != 0 || frame_cnt !== 16'(exp_frames) || to_pulses != start_to + 1) begin errors++; $display("FAIL to_summary: m_valid cycles=%0d frame_cnt=%0d pulses=%0d want 0/%0d/1", mv_cycles, frame_cnt, to_pulses - start_to, exp_frames); end
    endtask

    // Decoder answers on the very last allowed WAIT cycle: the result wins.
    task automatic test_valid_at_timeout();
        bit ok;
        int start_to;
        rand_frame();
        gap_cnt = 0; lat = TO - 1; m_ready = 1'b1; start_to = to_pulses;
        send_frame(1'b0);
        wait_mvalid(ok);
        checks++; if (!ok || m_data !== ref_decode() || to_pulses != start_to) begin errors++; $display("FAIL late_valid: valid=%b m_data=%h pulses=%0d want 1/%h/0", m_valid, m_data, to_pulses - start_to, ref_decode()); end
        exp_frames++;
        @(negedge clk);
        checks++; if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL late_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
    endtask

    task automatic test_reset_mid_feed();
        bit ok;
        int n = 0;
        rand_frame();
        gap_cnt = 0; lat = 3; m_ready = 1'b1;
        send_frame(1'b0);
        while (rx_cnt != 31 && n < 200) begin @(negedge clk); n++; end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_frames = 0;
        checks++; if (dec_valid_input !== 1'b0 || dec_reset !== 1'b1 || s_ready !== 1'b0) begin errors++; $display("FAIL mid_reset: valid=%b dec_reset=%b s_ready=%b want 0/1/0", dec_valid_input, dec_reset, s_ready); end
        rand_frame();
        gap_cnt = 0; lat = int'($urandom_range(0, 8));
        send_frame(1'b0);
        wait_mvalid(ok);
        checks++; if (!ok || m_data !== ref_decode() || rx_cnt != FS || gap_cnt != 0) begin errors++; $display("FAIL mid_next_frame: valid=%b m_data=%h rx=%0d gaps=%0d want 1/%h/%0d/0", m_valid, m_data, rx_cnt, gap_cnt, ref_decode(), FS); end
        exp_frames++;
        @(negedge clk);
        checks++; if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL mid_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        m_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            rand_frame();
            gap_cnt = 0; lat = int'($urandom_range(0, 10));
            send_frame(1'b0);
            wait_mvalid(ok);
            checks++; if (last_rst_run != RC) begin errors++; $display("FAIL b2b_dec_reset f%0d: pulse of %0d cycles want %0d", f, last_rst_run, RC); end
            checks++; if (!ok || m_data !== ref_decode()) begin errors++; $display("FAIL b2b_m_data f%0d: valid=%b got %h want %h", f, m_valid, m_data, ref_decode()); end
            exp_frames++;
            @(negedge clk);
            checks++; if (m_valid !== 1'b0 || frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL b2b_handshake f%0d: m_valid=%b frame_cnt=%0d want 0/%0d", f, m_valid, frame_cnt, exp_frames); end
        end
    endtask

    initial begin
        reset = 1'b1; s_valid = 1'b0; s_data = 2'b00; m_ready = 1'b0;
        dec_valid_output = 1'b0; dec_data_out = '0;
        test_reset();
        test_nominal();
        test_gaps();
        test_backpressure();
        test_timeout();
        test_valid_at_timeout();
        test_reset_mid_feed();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
